conv_channel_scheduler: RTL and testbench

// - Sequences a single shared KxK convolution engine across NUM_CH input channels and all OUT_DIM x OUT_DIM output positions.
// - Per position: issues one MAC request per channel, accumulates the partial sums, adds bias, applies ReLU, then emits one write.
// - Sits between the layer controller (start/done) and the conv engine plus the output feature-map buffer.

---
 rtl/conv_sched_pkg.sv | 31 +++
 rtl/conv_channel_scheduler_window_index_counter.sv | 39 +++
 rtl/conv_channel_scheduler.sv | 124 ++++++++++++
 tb/tb_conv_channel_scheduler.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_sched_pkg.sv
// Shared types and helpers for the convolution channel scheduler.
// CONV_SCHED_SATURATE_EN selects a saturating rather than wrapping output.
package conv_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_e;

    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Negative sums clamp to 0; optionally clamp to the positive maximum.
    function automatic logic signed [63:0] relu_sat(
        input logic signed [63:0] sum,
        input int                 wbit,
        input bit                 sat
    );
        logic signed [63:0] maxv;
        maxv = (64'sd1 <<< (wbit - 1)) - 64'sd1;
        if (sum < 0)
            return '0;
        if (sat && (sum > maxv))
            return maxv;
        return sum;
    endfunction

endpackage

// File: rtl/conv_channel_scheduler_window_index_counter.sv
// Row/column position counter over an OUT_DIM x OUT_DIM output map.
// Column advances first; last_pos flags the bottom-right position.
module window_index_counter
    import conv_sched_pkg::*;
#(
    parameter int OUT_DIM = 5,
    parameter int IDX_W   = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    output logic [IDX_W-1:0] row,
    output logic [IDX_W-1:0] col,
    output logic             last_pos
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(OUT_DIM - 1);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            row <= '0;
            col <= '0;
        end else if (clear) begin
            row <= '0;
            col <= '0;
        end else if (inc) begin
            if (col == LAST) begin
                col <= '0;
                row <= (row == LAST) ? '0 : row + IDX_W'(1);
            end else begin
                col <= col + IDX_W'(1);
            end
        end
    end

    assign last_pos = (row == LAST) && (col == LAST);

endmodule

// File: rtl/conv_channel_scheduler.sv
// Time-multiplexes one KxK conv engine over NUM_CH channels per output pixel.
// Build option: CONV_SCHED_SATURATE_EN clamps activations to the signed max.
module conv_channel_scheduler
    import conv_sched_pkg::*;
#(
    parameter  int SIZE      = 7,
    parameter  int SIZEKer   = 3,
    parameter  int NUM_CH    = 2,
    parameter  int WIDTH_BIT = 8,
    parameter  int ACC_W     = 24,
    localparam int OUT_DIM   = SIZE - SIZEKer + 1,
    localparam int IDX_W     = idx_width(OUT_DIM),
    localparam int CH_W      = idx_width(NUM_CH)
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        start,
    input  logic signed [WIDTH_BIT-1:0] bias,
    output logic                        busy,
    output logic                        done,
    output logic [IDX_W-1:0]            win_row,
    output logic [IDX_W-1:0]            win_col,
    output logic [CH_W-1:0]             ch_sel,
    output logic                        mac_req,
    input  logic                        mac_ack,
    input  logic signed [ACC_W-1:0]     mac_result,
    output logic                        wr_en,
    output logic [IDX_W-1:0]            wr_row,
    output logic [IDX_W-1:0]            wr_col,
    output logic signed [WIDTH_BIT-1:0] wr_data
);

    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_REQ   = REQ;
    localparam logic [1:0] S_WRITE = WRITE;
    localparam logic [1:0] S_DONE  = DONE;

    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

`ifdef CONV_SCHED_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic [1:0]                  state;
    logic [CH_W-1:0]             ch;
    logic signed [ACC_W-1:0]     acc;
    logic signed [WIDTH_BIT-1:0] bias_q;
    logic                        done_q;
    logic [IDX_W-1:0]            row;
    logic [IDX_W-1:0]            col;
    logic                        last_pos;
    logic                        cnt_clear;
    logic signed [63:0]          sum64;

    window_index_counter #(
        .OUT_DIM (OUT_DIM),
        .IDX_W   (IDX_W)
    ) u_idx (
        .clock    (clock),
        .reset    (reset),
        .clear    (cnt_clear),
        .inc      (wr_en),
        .row      (row),
        .col      (col),
        .last_pos (last_pos)
    );

    assign busy      = (state != S_IDLE);
    assign mac_req   = (state == S_REQ);
    assign wr_en     = (state == S_WRITE);
    assign done      = done_q;
    assign cnt_clear = (state == S_IDLE) && start;
    assign win_row   = row;
    assign win_col   = col;
    assign ch_sel    = ch;
    assign wr_row    = wr_en ? row : '0;
    assign wr_col    = wr_en ? col : '0;

    assign sum64   = 64'(acc) + 64'(bias_q);
    assign wr_data = wr_en ? WIDTH_BIT'(relu_sat(sum64, WIDTH_BIT, SAT)) : '0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= S_IDLE;
            ch     <= '0;
            acc    <= '0;
            bias_q <= '0;
            done_q <= 1'b0;
        end else begin
            // done trails the DONE state so it lands in the first idle cycle
            done_q <= (state == S_DONE);
            case (state)
                S_IDLE: begin
                    if (start) begin
                        bias_q <= bias;
                        ch     <= '0;
                        acc    <= '0;
                        state  <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (mac_ack) begin
                        acc <= acc + mac_result;
                        if (ch == LAST_CH)
                            state <= S_WRITE;
                        else
                            ch <= ch + CH_W'(1);
                    end
                end
                S_WRITE: begin
                    acc   <= '0;
                    ch    <= '0;
                    state <= last_pos ? S_DONE : S_REQ;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_channel_scheduler.sv
// Scoreboard bench for conv_channel_scheduler at OUT_DIM=2, NUM_CH=2.
// Honours CONV_SCHED_SATURATE_EN when computing expected activations.
module tb_conv_channel_scheduler;

    localparam int SIZE    = 4;
    localparam int SIZEKER = 3;
    localparam int NUM_CH  = 2;
    localparam int WB      = 8;
    localparam int ACC_W   = 24;
    localparam int OUT_DIM = SIZE - SIZEKER + 1;

    logic                 clock;
    logic                 reset;
    logic                 start;
    logic signed [WB-1:0] bias;
    logic                 busy;
    logic                 done;
    logic [0:0]           win_row;
    logic [0:0]           win_col;
    logic [0:0]           ch_sel;
    logic                 mac_req;
    logic                 mac_ack;
    logic signed [ACC_W-1:0] mac_result;
    logic                 wr_en;
    logic [0:0]           wr_row;
    logic [0:0]           wr_col;
    logic signed [WB-1:0] wr_data;

    conv_channel_scheduler #(
        .SIZE      (SIZE),
        .SIZEKer   (SIZEKER),
        .NUM_CH    (NUM_CH),
        .WIDTH_BIT (WB),
        .ACC_W     (ACC_W)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .bias       (bias),
        .busy       (busy),
        .done       (done),
        .win_row    (win_row),
        .win_col    (win_col),
        .ch_sel     (ch_sel),
        .mac_req    (mac_req),
        .mac_ack    (mac_ack),
        .mac_result (mac_result),
        .wr_en      (wr_en),
        .wr_row     (wr_row),
        .wr_col     (wr_col),
        .wr_data    (wr_data)
    );

    typedef struct {
        int         row;
        int         col;
        logic [7:0] data;
    } wr_t;

    wr_t exp_q[$];

    int passed = 0;
    int total  = 0;
    int write_count = 0;
    int ack_count   = 0;

    bit   stall_mode = 0;
    int   stall_cnt  = 0;
    int   res_base   = 0;
    int   res_chs    = 0;
    int   res_pos    = 0;
    int   bias_val   = 0;
    logic prev_wait  = 0;
    logic [2:0] prev_idx = '0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Engine model, write scoreboard and stall-time index checks.
    always @(negedge clock) begin
        mac_result = ACC_W'(res_base + int'(ch_sel) * res_chs
                     + (int'(win_row) * OUT_DIM + int'(win_col)) * res_pos);
        if (stall_mode && prev_wait && mac_req) begin
            total++;
            if ({win_row, win_col, ch_sel} !== prev_idx)
                $display("FAIL idx_stable: got %b want %b",
                         {win_row, win_col, ch_sel}, prev_idx);
            else
                passed++;
        end
        if (!stall_mode) begin
            mac_ack = 1'b1;
        end else if (mac_req) begin
            if (stall_cnt == 3) begin
                mac_ack   = 1'b1;
                stall_cnt = 0;
            end else begin
                mac_ack = 1'b0;
                stall_cnt++;
            end
        end else begin
            mac_ack   = 1'b0;
            stall_cnt = 0;
        end
        prev_wait = mac_req && !mac_ack;
        prev_idx  = {win_row, win_col, ch_sel};
        if (mac_req && mac_ack)
            ack_count++;
        if (wr_en) begin
            write_count++;
            total++;
            if (exp_q.size() == 0) begin
                $display("FAIL write_extra: got (%0d,%0d,%h) want none",
                         wr_row, wr_col, wr_data);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if (int'(wr_row) !== e.row || int'(wr_col) !== e.col ||
                    wr_data !== e.data)
                    $display("FAIL write: got (%0d,%0d,%h) want (%0d,%0d,%h)",
                             wr_row, wr_col, wr_data, e.row, e.col, e.data);
                else
                    passed++;
            end
        end
    end

    function automatic logic [7:0] model(input int r, input int c);
        int s;
        s = bias_val;
        for (int ch = 0; ch < NUM_CH; ch++)
            s += res_base + ch * res_chs + (r * OUT_DIM + c) * res_pos;
        if (s < 0)
            s = 0;
`ifdef CONV_SCHED_SATURATE_EN
        if (s > 127)
            s = 127;
`endif
        return 8'(s);
    endfunction

    task automatic setup(input int base, input int chs, input int pos,
                         input int b);
        wr_t e;
        res_base    = base;
        res_chs     = chs;
        res_pos     = pos;
        bias_val    = b;
        write_count = 0;
        ack_count   = 0;
        for (int r = 0; r < OUT_DIM; r++)
            for (int c = 0; c < OUT_DIM; c++) begin
                e.row  = r;
                e.col  = c;
                e.data = model(r, c);
                exp_q.push_back(e);
            end
    endtask

    task automatic do_start;
        @(negedge clock);
        bias  = WB'(bias_val);
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = -1;
        for (int i = 1; i <= 300; i++) begin
            @(posedge clock);
            #1;
            if (done) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        total++;
        if ({busy, done, mac_req, wr_en, win_row, win_col, ch_sel,
             wr_row, wr_col, wr_data} !== 17'd0)
            $display("FAIL reset_outputs: got nonzero want 0");
        else
            passed++;
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            total++;
            if ({busy, done, wr_en, mac_req} !== 4'b0)
                $display("FAIL idle_quiet: got %b want 0000",
                         {busy, done, wr_en, mac_req});
            else
                passed++;
        end
    endtask

    task automatic test_pass(input string name, input int base,
                             input int b);
        int cyc;
        setup(base, 0, 0, b);
        do_start();
        wait_done(cyc);
        total++;
        if (cyc !== 13)
            $display("FAIL %s_latency: got %0d want 13", name, cyc);
        else
            passed++;
        total++;
        if (busy !== 1'b0)
            $display("FAIL %s_busy_done: got %b want 0", name, busy);
        else
            passed++;
        total++;
        if (write_count !== 4 || exp_q.size() !== 0)
            $display("FAIL %s_writes: got %0d left %0d want 4 left 0",
                     name, write_count, exp_q.size());
        else
            passed++;
        total++;
        if (ack_count !== 8)
            $display("FAIL %s_acks: got %0d want 8", name, ack_count);
        else
            passed++;
        @(posedge clock);
        #1;
        total++;
        if (done !== 1'b0)
            $display("FAIL %s_done_pulse: got %b want 0", name, done);
        else
            passed++;
    endtask

    task automatic test_stall;
        int cyc;
        stall_mode = 1;
        setup(7, 4, -5, -2);
        do_start();
        wait_done(cyc);
        total++;
        if (cyc !== 37)
            $display("FAIL stall_latency: got %0d want 37", cyc);
        else
            passed++;
        total++;
        if (write_count !== 4 || exp_q.size() !== 0 || ack_count !== 8)
            $display("FAIL stall_counts: got w%0d q%0d a%0d want w4 q0 a8",
                     write_count, exp_q.size(), ack_count);
        else
            passed++;
        stall_mode = 0;
        setup(7, 4, -5, -2);
        do_start();
        wait_done(cyc);
        total++;
        if (write_count !== 4 || exp_q.size() !== 0)
            $display("FAIL nostall_ref: got w%0d q%0d want w4 q0",
                     write_count, exp_q.size());
        else
            passed++;
    endtask

    task automatic test_mid_start;
        int cyc;
        setup(3, 1, 2, 1);
        do_start();
        cyc = -1;
        for (int i = 1; i <= 300; i++) begin
            @(posedge clock);
            #1;
            if (i == 5) begin
                bias  = 8'sd100;
                start = 1'b1;
            end
            if (i == 6)
                start = 1'b0;
            if (done) begin
                cyc = i;
                break;
            end
        end
        total++;
        if (cyc !== 13 || write_count !== 4 || exp_q.size() !== 0)
            $display("FAIL mid_start: got c%0d w%0d q%0d want c13 w4 q0",
                     cyc, write_count, exp_q.size());
        else
            passed++;
        repeat (20) @(posedge clock);
        #1;
        total++;
        if (busy !== 1'b0 || write_count !== 4)
            $display("FAIL mid_start_restart: got b%b w%0d want b0 w4",
                     busy, write_count);
        else
            passed++;
    endtask

    task automatic test_reset_mid;
        int cyc;
        bit saw_done;
        setup(10, 0, 0, 5);
        do_start();
        repeat (5) @(posedge clock);
        #3 reset = 1'b1;
        #1;
        total++;
        if ({busy, done, mac_req, wr_en, win_row, win_col, ch_sel,
             wr_row, wr_col, wr_data} !== 17'd0)
            $display("FAIL reset_mid_outputs: got nonzero want 0");
        else
            passed++;
        exp_q.delete();
        repeat (2) @(negedge clock);
        reset    = 1'b0;
        saw_done = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (done || busy)
                saw_done = 1;
        end
        total++;
        if (saw_done !== 1'b0)
            $display("FAIL reset_mid_no_done: got 1 want 0");
        else
            passed++;
        setup(-1, 6, 9, -4);
        do_start();
        wait_done(cyc);
        total++;
        if (cyc !== 13 || write_count !== 4 || exp_q.size() !== 0)
            $display("FAIL reset_mid_repass: got c%0d w%0d q%0d want c13 w4 q0",
                     cyc, write_count, exp_q.size());
        else
            passed++;
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        bias       = '0;
        mac_ack    = 1'b0;
        mac_result = '0;
        test_reset();
        test_pass("basic", 10, 5);
        test_pass("relu", -20, 3);
        test_pass("wrap", 100, 0);
        test_stall();
        test_mid_start();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
